demux_1x8_sched: RTL and testbench
==================================

Name: demux_1x8_sched

Overview:
- Handshaked scheduler that drives a 1-to-8 demux datapath from a single input stream.
- Accepts one word with either a destination select or a broadcast request.
- Steers the word to the addressed channel, or walks it across a channel mask one channel at a time.
- Sits between a single producer and eight consumer channels; the shared out_data bus plus the one-hot out_valid form the demux output.

Parameters:
- DW, 8, data width of in_data/out_data
- TIMEOUT, 16, stall-cycle limit per channel (used only with the optional feature); must be >= 2

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  producer word valid
- in_ready  output  1  scheduler can accept a word
- in_data  input  DW  word to deliver
- in_sel  input  3  destination channel when in_bcast=0
- in_bcast  input  1  broadcast request; uses cfg_mask
- cfg_mask  input  8  broadcast channel enable, sampled at accept
- out_valid  output  8  one-hot channel valid (demux output)
- out_ready  input  8  per-channel ready
- out_data  output  DW  shared data to all channels
- busy  output  1  transaction in progress
- done  output  1  one-cycle pulse when a transaction completes
- err  output  1  one-cycle pulse on channel timeout
- err_ch  output  3  channel that timed out; held until the next err

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; data, sel, mask and pointer registers all cleared.
  - out_valid=0, out_data=0, busy=0, done=0, err=0, err_ch=0.
  - in_ready=0 while rst_n=0.
- FSM states: IDLE, SEND, BCAST.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register in_data, in_sel, in_bcast and cfg_mask.
  - bcast=0 -> SEND.
  - bcast=1, mask!=0 -> BCAST, ptr = lowest set mask bit.
  - bcast=1, mask==0 -> stay IDLE; done pulses next cycle; no out_valid.
- SEND:
  - out_valid = onehot(sel_q); out_data = data_q.
  - On out_ready[sel_q]: -> IDLE, done=1 on the next cycle.
- BCAST:
  - out_valid = onehot(ptr); out_data = data_q.
  - On out_ready[ptr]: ptr moves to the next higher set bit of mask_q.
  - If no higher set bit remains: -> IDLE with done pulse.
- Timing:
  - Latency is one cycle: a word accepted in cycle N has out_valid in cycle N+1.
  - in_ready=0 in SEND and BCAST, so there is no back-to-back accept.
  - Maximum rate is one single-channel word per 2 cycles.
- Valid/ready rules:
  - out_valid and out_data are registered and stay stable until the handshake completes.
  - out_valid is never retracted without a handshake (except on timeout or reset).
  - out_ready on non-selected channels is ignored.
  - At most one out_valid bit is high at any time.
  - cfg_mask, in_sel and in_data changes after accept have no effect.
- busy = (state != IDLE).
- Reset mid-transaction: outputs clear immediately (async); the held word is discarded with no done pulse.

Optional Feature:
- Macro: DEMUX_SCHED_TIMEOUT_EN.
- Defined:
  - A stall counter increments each cycle with out_valid set and out_ready[active]=0, and clears on handshake or channel change.
  - When it reaches TIMEOUT, the current channel is dropped: err pulses 1 cycle and err_ch = that channel.
  - SEND goes to IDLE with a done pulse.
  - BCAST advances to the next set bit, or goes to IDLE with done if none remain.
- Undefined:
  - No counter; the scheduler waits indefinitely.
  - err=0 and err_ch=0 constant; the ports remain present.

Decomposition:
- Shared package demux_sched_pkg holds:
  - NCH=8 and SELW=3 constants
  - state typedef {IDLE, SEND, BCAST}
  - a function onehot(sel)
- One sub-module: demux_next_ch.
  - Combinational.
  - Input: mask[7:0] and current ptr.
  - Output: next higher set bit index plus a "none" flag.
  - Also used with ptr=-1 semantics (flag input) to find the first set bit at accept.

Test Plan:
- Basic: reset, then accept data=8'hA5, sel=3, bcast=0, out_ready=8'hFF -> next cycle out_valid=8'b0000_1000, out_data=8'hA5; handshake; done pulse; busy 1->0; in_ready back to 1.
- Backpressure: sel=5, out_ready[5]=0 for 4 cycles -> out_valid[5] and out_data held stable, in_ready=0, no done; raise out_ready[5] -> completes, done pulse one cycle after the handshake.
- Broadcast: data=8'h3C, cfg_mask=8'b1010_0101, all ready -> out_valid visits ch0, ch2, ch5, ch7 on consecutive cycles; done after ch7. cfg_mask changed to 8'hFF mid-walk -> order unchanged.
- Empty broadcast: bcast=1, cfg_mask=0 -> accepted; done pulses next cycle; out_valid stays 0; busy stays 0.
- Reset mid-broadcast (mask 8'hFF, after the ch2 handshake): rst_n low -> out_valid=0, busy=0 immediately; after release in_ready=1 and a new sel=1 word completes normally.
- Timeout (macro on, TIMEOUT=4):
  - sel=6 with out_ready=0 -> after 4 stall cycles err=1 for one cycle, err_ch=6, done pulses, back to IDLE.
  - Broadcast mask 8'b0100_0010 with ch1 stalled -> err_ch=1, then ch6 delivered.
  - Macro off, same stall -> waits 100 cycles with err=0.

Source files
------------

// File: rtl/demux_sched_pkg.sv
// Shared constants, FSM state type and one-hot helper for the 1x8 demux scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package demux_sched_pkg;

    localparam int NCH  = 8;
    localparam int SELW = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        BCAST = 2'd2
    } state_t;

    // Channel index to one-hot channel valid vector.
    function automatic logic [NCH-1:0] onehot(input logic [SELW-1:0] sel);
        logic [NCH-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/demux_1x8_sched_if.sv
// Producer-side and channel-side handshake bundle of the 1x8 demux scheduler.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready toward the producer, out_valid/out_ready per channel.
interface demux_1x8_sched_if
    import demux_sched_pkg::*;
#(
    parameter int DW = 8
) ();

    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic [SELW-1:0] in_sel;
    logic            in_bcast;
    logic [NCH-1:0]  cfg_mask;
    logic [NCH-1:0]  out_valid;
    logic [NCH-1:0]  out_ready;
    logic [DW-1:0]   out_data;

    // Scheduler side.
    modport master (
        input  in_valid, in_data, in_sel, in_bcast, cfg_mask, out_ready,
        output in_ready, out_valid, out_data
    );

    // Producer / consumer side.
    modport slave (
        output in_valid, in_data, in_sel, in_bcast, cfg_mask, out_ready,
        input  in_ready, out_valid, out_data
    );

endinterface

// File: rtl/demux_next_ch.sv
// Finds the lowest set mask bit above i_ptr, or the lowest set bit overall when i_from_start=1.
// Latency: combinational.
// Backpressure: none; o_none=1 when no qualifying bit exists.
module demux_next_ch
    import demux_sched_pkg::*;
(
    input  logic [NCH-1:0]  i_mask,
    input  logic [SELW-1:0] i_ptr,
    input  logic            i_from_start,
    output logic [SELW-1:0] o_nxt,
    output logic            o_none
);

    // Scan from the top down so the last hit is the lowest qualifying index.
    always_comb begin
        o_nxt  = '0;
        o_none = 1'b1;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (i_mask[i] && (i_from_start || (SELW'(i) > i_ptr))) begin
                o_nxt  = SELW'(i);
                o_none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/demux_1x8_sched.sv
// Steers one accepted word to a selected channel or walks it across a broadcast mask.
// Latency: 1 cycle accept-to-out_valid; one word in flight, so in_ready=0 while busy.
// Backpressure: holds out_valid/out_data until out_ready[active]; DEMUX_SCHED_TIMEOUT_EN drops a stalled channel.
module demux_1x8_sched
    import demux_sched_pkg::*;
#(
    parameter int DW      = 8,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    demux_1x8_sched_if.master bus,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [SELW-1:0] err_ch
);

    state_t          r_state;
    logic [DW-1:0]   r_data;
    logic [SELW-1:0] r_sel;
    logic [SELW-1:0] r_ptr;
    logic [NCH-1:0]  r_mask;
    logic [NCH-1:0]  r_out_valid;
    logic            r_done;

    logic            w_idle;
    logic            w_acc;
    logic [SELW-1:0] w_act;
    logic            w_hs;
    logic            w_to;
    logic            w_drop;
    logic [SELW-1:0] w_nxt;
    logic            w_none;

    assign w_idle = (r_state == IDLE);
    assign w_acc  = bus.in_valid && bus.in_ready;
    assign w_act  = (r_state == SEND) ? r_sel : r_ptr;
    // Only the active channel's ready matters; other channels are ignored.
    assign w_hs   = !w_idle && bus.out_ready[w_act];
    assign w_drop = w_hs || w_to;

    // In IDLE search the incoming mask from bit 0; otherwise search the held mask above ptr.
    demux_next_ch u_next_ch (
        .i_mask       (w_idle ? bus.cfg_mask : r_mask),
        .i_ptr        (r_ptr),
        .i_from_start (w_idle),
        .o_nxt        (w_nxt),
        .o_none       (w_none)
    );

    // Scheduler FSM with registered channel valid, data and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_data      <= '0;
            r_sel       <= '0;
            r_ptr       <= '0;
            r_mask      <= '0;
            r_out_valid <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_acc) begin
                        r_data <= bus.in_data;
                        r_sel  <= bus.in_sel;
                        r_mask <= bus.cfg_mask;
                        if (!bus.in_bcast) begin
                            r_state     <= SEND;
                            r_out_valid <= onehot(bus.in_sel);
                        end else if (!w_none) begin
                            r_state     <= BCAST;
                            r_ptr       <= w_nxt;
                            r_out_valid <= onehot(w_nxt);
                        end else begin
                            // Empty broadcast: nothing to deliver, complete at once.
                            r_done <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (w_drop) begin
                        r_state     <= IDLE;
                        r_out_valid <= '0;
                        r_done      <= 1'b1;
                    end
                end
                BCAST: begin
                    if (w_drop) begin
                        if (w_none) begin
                            r_state     <= IDLE;
                            r_out_valid <= '0;
                            r_done      <= 1'b1;
                        end else begin
                            r_ptr       <= w_nxt;
                            r_out_valid <= onehot(w_nxt);
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= '0;
                end
            endcase
        end
    end

`ifdef DEMUX_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0]   r_stall;
    logic            r_err;
    logic [SELW-1:0] r_err_ch;

    // Drop on the TIMEOUT-th consecutive stalled cycle of the same channel.
    assign w_to = !w_idle && !w_hs && (r_stall == CW'(TIMEOUT - 1));

    // Stall counter per active channel plus the error pulse and sticky channel id.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall  <= '0;
            r_err    <= 1'b0;
            r_err_ch <= '0;
        end else begin
            r_err <= w_to;
            if (w_to) begin
                r_err_ch <= w_act;
            end
            if (w_idle || w_hs || w_to) begin
                r_stall <= '0;
            end else begin
                r_stall <= r_stall + 1'b1;
            end
        end
    end

    assign err    = r_err;
    assign err_ch = r_err_ch;
`else
    assign w_to   = 1'b0;
    assign err    = 1'b0;
    assign err_ch = '0;
`endif

    assign bus.in_ready  = rst_n && w_idle;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_data;
    assign busy          = !w_idle;
    assign done          = r_done;

endmodule

// File: tb/tb_demux_1x8_sched.sv
// Randomized and directed bench for demux_1x8_sched against a queue-based delivery model.
// Latency: model predicts outputs one cycle after each accept/handshake.
// Backpressure: exercised via per-channel out_ready patterns, including long stalls.
module tb_demux_1x8_sched;
    import demux_sched_pkg::*;

    localparam int DW = 8;
    localparam int TO = 4;
`ifdef DEMUX_SCHED_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] err_ch;

    always #5 clk = ~clk;

    demux_1x8_sched_if #(.DW(DW)) bus ();

    demux_1x8_sched #(.DW(DW), .TIMEOUT(TO)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .err_ch (err_ch)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model: queue of channels still owed a delivery, front is the active one.
    int         m_q[$];
    logic [7:0] m_data;
    logic       m_done;
    logic       m_err;
    logic [2:0] m_errch;
    int         m_stall;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_data  = '0;
        m_done  = 1'b0;
        m_err   = 1'b0;
        m_errch = '0;
        m_stall = 0;
    endtask

    task automatic check_outputs();
        logic [7:0] ev;
        ev = (m_q.size() != 0) ? 8'(1 << m_q[0]) : 8'h00;
        check_eq("out_valid", 32'(bus.out_valid), 32'(ev));
        if (m_q.size() != 0) check_eq("out_data", 32'(bus.out_data), 32'(m_data));
        check_eq("busy", 32'(busy), 32'(m_q.size() != 0));
        check_eq("in_ready", 32'(bus.in_ready), 32'(m_q.size() == 0));
        check_eq("done", 32'(done), 32'(m_done));
        check_eq("err", 32'(err), 32'(m_err));
        check_eq("err_ch", 32'(err_ch), 32'(m_errch));
    endtask

    // Called at a falling edge: check, drive the next inputs, advance the model, wait one cycle.
    task automatic step(input logic v, input logic [7:0] d, input logic [2:0] s,
                        input logic b, input logic [7:0] m, input logic [7:0] rdy);
        logic nd;
        logic ne;
        check_outputs();
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_sel    = s;
        bus.in_bcast  = b;
        bus.cfg_mask  = m;
        bus.out_ready = rdy;
        nd = 1'b0;
        ne = 1'b0;
        if (m_q.size() == 0) begin
            m_stall = 0;
            if (v) begin
                m_data = d;
                if (!b) m_q.push_back(int'(s));
                else for (int i = 0; i < 8; i++) if (m[i]) m_q.push_back(i);
                if (m_q.size() == 0) nd = 1'b1;
            end
        end else if (rdy[m_q[0]]) begin
            void'(m_q.pop_front());
            m_stall = 0;
            if (m_q.size() == 0) nd = 1'b1;
        end else if (TO_EN) begin
            m_stall++;
            if (m_stall == TO) begin
                m_errch = 3'(m_q.pop_front());
                ne      = 1'b1;
                m_stall = 0;
                if (m_q.size() == 0) nd = 1'b1;
            end
        end
        m_done = nd;
        m_err  = ne;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic [7:0] rdy, input logic [7:0] m);
        for (int k = 0; k < n; k++) step(1'b0, 8'h00, 3'd0, 1'b0, m, rdy);
    endtask

    initial begin
        logic [7:0] rdy;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_sel    = '0;
        bus.in_bcast  = 1'b0;
        bus.cfg_mask  = '0;
        bus.out_ready = '0;
        model_reset();

        // Reset state.
        #1 rst_n = 1'b0;
        #2;
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check_eq("rst_out_data", 32'(bus.out_data), 32'h0);
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_done", 32'(done), 32'h0);
        check_eq("rst_err", 32'(err), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic single-channel delivery.
        step(1'b1, 8'hA5, 3'd3, 1'b0, 8'h00, 8'hFF);
        check_eq("basic_ov", 32'(bus.out_valid), 32'h08);
        check_eq("basic_od", 32'(bus.out_data), 32'hA5);
        idle(3, 8'hFF, 8'h00);

        // Backpressure on channel 5 while other channels are ready.
        step(1'b1, 8'h5A, 3'd5, 1'b0, 8'h00, 8'hDF);
        idle(3, 8'hDF, 8'h00);
        idle(3, 8'hFF, 8'h00);

        // Broadcast walk; cfg_mask changes mid-walk must not matter.
        step(1'b1, 8'h3C, 3'd0, 1'b1, 8'hA5, 8'hFF);
        check_eq("bcast_first", 32'(bus.out_valid), 32'h01);
        idle(6, 8'hFF, 8'hFF);

        // Empty broadcast.
        step(1'b1, 8'h77, 3'd0, 1'b1, 8'h00, 8'hFF);
        idle(3, 8'hFF, 8'h00);

        // Reset in the middle of a full-mask broadcast, after the ch2 handshake.
        step(1'b1, 8'h11, 3'd0, 1'b1, 8'hFF, 8'hFF);
        idle(3, 8'hFF, 8'h00);
        check_eq("pre_rst_ov", 32'(bus.out_valid), 32'h08);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("mid_rst_ov", 32'(bus.out_valid), 32'h0);
        check_eq("mid_rst_busy", 32'(busy), 32'h0);
        check_eq("mid_rst_in_ready", 32'(bus.in_ready), 32'h0);
        check_eq("mid_rst_od", 32'(bus.out_data), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        step(1'b1, 8'h22, 3'd1, 1'b0, 8'h00, 8'hFF);
        idle(3, 8'hFF, 8'h00);

        // Long stall on channel 6, then release.
        step(1'b1, 8'h66, 3'd6, 1'b0, 8'h00, 8'h00);
        idle(100, 8'h00, 8'h00);
        idle(3, 8'hFF, 8'h00);

        // Broadcast with channel 1 stalled.
        step(1'b1, 8'h42, 3'd0, 1'b1, 8'h42, 8'hFF);
        idle(6, 8'hFD, 8'h00);
        idle(3, 8'hFF, 8'h00);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 9) == 0) rdy = 8'($urandom);
            else if ($urandom_range(0, 19) == 0) rdy = 8'h00;
            else rdy = ~(8'($urandom) & 8'($urandom));
            step(1'($urandom_range(0, 1)), 8'($urandom), 3'($urandom),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom),
                 rdy);
        end
        idle(2, 8'hFF, 8'h00);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
